// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the fetch/issue front end and the stages that follow:
//   INSTR_W      - instruction word width
//   PC_INC       - byte distance between consecutive instruction words
//   dlv_state_e  - delivery (decode-facing) FSM states
//   fet_state_e  - fetch (memory-facing) FSM states
//   next_pc()    - sequential PC step, wraps modulo 2^32
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        DLV_EMPTY   = 2'd0,
        DLV_PRESENT = 2'd1,
        DLV_GAP     = 2'd2
    } dlv_state_e;

    typedef enum logic [1:0] {
        FET_IDLE    = 2'd0,
        FET_REQ     = 2'd1,
        FET_DISCARD = 2'd2
    } fet_state_e;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/issuer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small single-clock FIFO with a combinational head view.
//   clk, reset_n      - clock, asynchronous active-low reset (pointers/count)
//   push, push_data   - write one entry (ignored when full or flushing)
//   pop               - drop the head entry (ignored when empty or flushing)
//   flush             - discard all entries; dominates push and pop
//   count             - current occupancy, 0..DEPTH
//   head              - oldest entry, valid while empty=0
//   empty, full       - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    // One register per entry; each only loads when the write pointer selects it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= push_data;
            end
        end

        assign entries[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = entries[rd_ptr_reg];

endmodule

// File: rtl/issuer.sv
// -----------------------------------------------------------------------------
// issuer
// Instruction fetch/issue stage feeding decode.
// Fetches words at a running PC into a prefetch FIFO and presents the FIFO
// head to decode with a two-phase toggle handshake.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   dataOut, readyOut            - presented instruction and its valid flag
//   triggerIn                    - decode toggle; every edge consumes a word
//   imem_req, imem_addr          - fetch request and word-aligned address
//   imem_ack, imem_rdata         - fetch completion and returned word
//   redirect_valid, redirect_pc  - one-cycle PC redirect from execute
//   protoErr                     - sticky: toggle seen with nothing presented
// -----------------------------------------------------------------------------
module issuer
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [INSTR_W-1:0] dataOut,
    output logic               readyOut,
    input  logic               triggerIn,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               protoErr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------
    // Toggle synchroniser and edge detect
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   toggle_edge;

    // Preload every stage with the live level so leaving reset never
    // looks like a toggle, whatever level decode left the line at.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {SYNC_STAGES{triggerIn}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], triggerIn};
        end
    end

    assign toggle_edge = sync_reg[SYNC_STAGES-1] ^ sync_reg[SYNC_STAGES-2];

    // ---------------------------------------------------------------
    // Redirect target (low address bits are not meaningful)
    // ---------------------------------------------------------------
    logic [31:0] redirect_target;
    logic [1:0]  unused_pc_lsb;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb   = redirect_pc[1:0];

    // ---------------------------------------------------------------
    // Prefetch FIFO
    // ---------------------------------------------------------------
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [INSTR_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // ---------------------------------------------------------------
    // Delivery FSM
    // ---------------------------------------------------------------
    dlv_state_e         dlv_reg;
    dlv_state_e         dlv_next;
    logic [INSTR_W-1:0] data_reg;
    logic [INSTR_W-1:0] data_next;
    logic               ready_reg;
    logic               ready_next;
    logic               perr_reg;
    logic               perr_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dlv_reg   <= DLV_EMPTY;
            data_reg  <= '0;
            ready_reg <= 1'b0;
            perr_reg  <= 1'b0;
        end else begin
            dlv_reg   <= dlv_next;
            data_reg  <= data_next;
            ready_reg <= ready_next;
            perr_reg  <= perr_next;
        end
    end

    always_comb begin
        dlv_next   = dlv_reg;
        data_next  = data_reg;
        ready_next = ready_reg;
        perr_next  = perr_reg;
        fifo_pop   = 1'b0;

        if (redirect_valid) begin
            // Whatever is presented belongs to the old stream. A toggle
            // arriving now acknowledges that stale word, so it is simply
            // absorbed: no pop, no error.
            dlv_next   = DLV_EMPTY;
            ready_next = 1'b0;
        end else begin
            case (dlv_reg)
                DLV_EMPTY: begin
                    if (toggle_edge) begin
                        perr_next = 1'b1;
                    end
                    if (!fifo_empty) begin
                        data_next  = fifo_head;
                        ready_next = 1'b1;
                        dlv_next   = DLV_PRESENT;
                    end
                end
                DLV_PRESENT: begin
                    if (toggle_edge) begin
                        fifo_pop   = 1'b1;
                        ready_next = 1'b0;
                        dlv_next   = DLV_GAP;
                    end
                end
                DLV_GAP: begin
                    // Single-cycle bubble so readyOut is seen low between words.
                    if (toggle_edge) begin
                        perr_next = 1'b1;
                    end
                    if (!fifo_empty) begin
                        data_next  = fifo_head;
                        ready_next = 1'b1;
                        dlv_next   = DLV_PRESENT;
                    end else begin
                        dlv_next   = DLV_EMPTY;
                    end
                end
                default: begin
                    dlv_next   = DLV_EMPTY;
                    ready_next = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dataOut  = data_reg;
        readyOut = ready_reg;
        protoErr = perr_reg;
    end

    // ---------------------------------------------------------------
    // Fetch FSM
    // ---------------------------------------------------------------
    fet_state_e  fet_reg;
    fet_state_e  fet_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] addr_reg;
    logic [31:0] addr_next;
    logic        space_after_push;

    // The ack cycle's push has not reached the count yet, so it is added
    // here; a pending pop is ignored, which keeps a full push impossible.
    assign space_after_push = (int'(fifo_count) + 1) < FIFO_DEPTH;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fet_reg  <= FET_IDLE;
            pc_reg   <= RESET_PC;
            addr_reg <= '0;
        end else begin
            fet_reg  <= fet_next;
            pc_reg   <= pc_next;
            addr_reg <= addr_next;
        end
    end

    always_comb begin
        fet_next  = fet_reg;
        pc_next   = pc_reg;
        addr_next = addr_reg;
        fifo_push = 1'b0;

        case (fet_reg)
            FET_IDLE: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (!fifo_full) begin
                    fet_next  = FET_REQ;
                    addr_next = pc_reg;
                end
            end
            FET_REQ: begin
                if (redirect_valid) begin
                    // The in-flight word is stale; if it has not returned
                    // yet, wait it out in DISCARD with req/addr held.
                    pc_next  = redirect_target;
                    fet_next = imem_ack ? FET_IDLE : FET_DISCARD;
                end else if (imem_ack) begin
                    fifo_push = 1'b1;
                    pc_next   = next_pc(pc_reg);
                    if (space_after_push) begin
                        fet_next  = FET_REQ;
                        addr_next = next_pc(pc_reg);
                    end else begin
                        fet_next  = FET_IDLE;
                    end
                end
            end
            FET_DISCARD: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (imem_ack) begin
                    fet_next = FET_IDLE;
                end
            end
            default: begin
                fet_next = FET_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req  = (fet_reg != FET_IDLE);
        imem_addr = addr_reg;
    end

endmodule

// File: tb/tb_issuer.sv
// -----------------------------------------------------------------------------
// tb_issuer
// Directed bench for issuer: behavioural instruction memory with adjustable
// ack latency, a presentation monitor, and hand-computed expected words.
// Memory contents: addr < 0x100 -> 0xE3A00001 + (addr/4)*0x1001
//                  otherwise    -> 0xA5000000 ^ addr
// -----------------------------------------------------------------------------
module tb_issuer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] dataOut;
    logic        readyOut;
    logic        triggerIn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        protoErr;

    always #5 clk = ~clk;

    issuer #(
        .RESET_PC    (32'h0000_0000),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dataOut        (dataOut),
        .readyOut       (readyOut),
        .triggerIn      (triggerIn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .protoErr       (protoErr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%h", tag, got);
        end else begin
            $display("FAIL %-14s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    int          mem_delay    = 0;
    bit          mem_pending  = 1'b0;
    int          mem_cnt      = 0;
    logic [31:0] mem_lat_addr = 32'h0;
    logic [31:0] req_log[$];
    logic [31:0] pres_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h100) return 32'hE3A0_0001 + (a >> 2) * 32'h1001;
        return 32'hA500_0000 ^ a;
    endfunction

    // Accepts a request at a falling edge, answers after mem_delay more
    // falling edges. A pending answer is delivered even across a DUT reset.
    always @(negedge clk) begin
        if (imem_ack) begin
            imem_ack = 1'b0;
        end else if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ack    = 1'b1;
                imem_rdata  = mem_word(mem_lat_addr);
                mem_pending = 1'b0;
            end
        end else if (imem_req) begin
            mem_lat_addr = imem_addr;
            req_log.push_back(imem_addr);
            $display("req  addr=%h", imem_addr);
            if (mem_delay == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                mem_cnt     = mem_delay;
                mem_pending = 1'b1;
            end
        end
    end

    // ---------------- presentation monitor ----------------
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    int          viol       = 0;

    always @(negedge clk) begin
        if (readyOut && !prev_ready) begin
            pres_log.push_back(dataOut);
            $display("pres data=%h", dataOut);
        end
        if (readyOut && prev_ready && (dataOut !== prev_data)) viol++;
        prev_ready = readyOut;
        prev_data  = dataOut;
    end

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pres_at(input int i);
        if (i < pres_log.size()) return pres_log[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max && !imem_req; i++) @(negedge clk);
    endtask

    logic [31:0] t2_data [3] = '{32'hE3A0_1002, 32'hE3A0_2003, 32'hE3A0_3004};
    logic [31:0] t2_addr [3] = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0018};

    initial begin
        int r, p;
        reset_n        = 1'b0;
        triggerIn      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        cycles(3);
        check("rst_ready", 32'(readyOut), 0);
        check("rst_req",   32'(imem_req), 0);
        check("rst_data",  dataOut, 0);
        check("rst_addr",  imem_addr, 0);
        check("rst_perr",  32'(protoErr), 0);
        reset_n = 1'b1;

        // 1) fill after reset, first word presented without a toggle
        cycles(30);
        for (int i = 0; i < 4; i++) check($sformatf("t1_addr%0d", i), req_at(i), 32'(4 * i));
        check("t1_nreq",    32'(req_log.size()), 4);
        check("t1_ready",   32'(readyOut), 1);
        check("t1_data",    dataOut, 32'hE3A0_0001);
        check("t1_reqstop", 32'(imem_req), 0);

        // 2) three toggles, each pops one word; fetch refills
        for (int i = 0; i < 3; i++) begin
            triggerIn = ~triggerIn;
            cycles(8);
            check($sformatf("t2_data%0d", i), dataOut, t2_data[i]);
        end
        cycles(10);
        for (int i = 0; i < 3; i++) check($sformatf("t2_addr%0d", i), req_at(4 + i), t2_addr[i]);
        check("t2_perr", 32'(protoErr), 0);

        // 3) redirect while a slow fetch is outstanding
        r = req_log.size();
        mem_delay = 5;
        triggerIn = ~triggerIn;
        wait_req(20);
        cycles(2);
        p = pres_log.size();
        pulse_redirect(32'h0000_0100);
        check("t3_reqhold",  32'(imem_req), 1);
        check("t3_addrhold", imem_addr, 32'h0000_001C);
        mem_delay = 0;
        cycles(30);
        check("t3_stale",  req_at(r), 32'h0000_001C);
        check("t3_newreq", req_at(r + 1), 32'h0000_0100);
        check("t3_pres",   pres_at(p), 32'hA500_0100);

        // 4) redirect coinciding with a toggle edge
        cycles(5);
        p = pres_log.size();
        triggerIn = ~triggerIn;
        @(negedge clk);
        pulse_redirect(32'h0000_0200);
        cycles(30);
        check("t4_pres",  pres_at(p), 32'hA500_0200);
        check("t4_data",  dataOut, 32'hA500_0200);
        check("t4_perr",  32'(protoErr), 0);

        // 5) toggle with nothing presented
        mem_delay = 30;
        p = pres_log.size();
        pulse_redirect(32'h0000_0300);
        cycles(3);
        mem_delay = 0;
        triggerIn = ~triggerIn;
        cycles(6);
        check("t5_perr",   32'(protoErr), 1);
        check("t5_ready",  32'(readyOut), 0);
        cycles(50);
        check("t5_pres",   pres_at(p), 32'hA500_0300);
        check("t5_data",   dataOut, 32'hA500_0300);
        check("t5_sticky", 32'(protoErr), 1);

        // 6) PC wrap at the top of the address space
        r = req_log.size();
        p = pres_log.size();
        pulse_redirect(32'hFFFF_FFFE);
        cycles(30);
        check("t6_addr_top", req_at(r), 32'hFFFF_FFFC);
        check("t6_addr_wrap", req_at(r + 1), 32'h0000_0000);
        check("t6_pres",     pres_at(p), 32'h5AFF_FFFC);

        // 7) reset asserted in the middle of an outstanding fetch
        mem_delay = 10;
        pulse_redirect(32'h0000_0400);
        wait_req(20);
        cycles(2);
        #2 reset_n = 1'b0;
        #1;
        check("t7_req",   32'(imem_req), 0);
        check("t7_addr",  imem_addr, 0);
        check("t7_ready", 32'(readyOut), 0);
        check("t7_data",  dataOut, 0);
        check("t7_perr",  32'(protoErr), 0);
        mem_delay = 0;
        r = req_log.size();
        p = pres_log.size();
        cycles(15);
        reset_n = 1'b1;
        cycles(30);
        check("t7_addr0", req_at(r), 32'h0000_0000);
        check("t7_addr1", req_at(r + 1), 32'h0000_0004);
        check("t7_pres",  pres_at(p), 32'hE3A0_0001);
        check("t7_dnow",  dataOut, 32'hE3A0_0001);

        check("data_stable", 32'(viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog    got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
